// File: rtl/seg_transition_ctl.sv
// -----------------------------------------------------------------------------
// seg_transition_ctl
//
// Chooses which of the two buffer segments (0/1) the modulation/STM read path
// plays. A host UPDATE latches a target segment, a transition mode and a mode
// argument. The block waits for that mode's trigger and then flips the active
// segment. Per-segment repeat counts make the read path stop once a finite
// count runs out. In EXT mode the block instead alternates between the two
// segments.
//
// Optional feature macro: TRANSITION_GPIO_EN
//   defined   -> mode 0x02 (GPIO) is valid and uses a GPIO rising-edge trigger
//   undefined -> mode 0x02 is rejected like any unknown code; i_gpio_in unused
//
// Ports:
//   i_clk               system clock, rising edge
//   i_rst               synchronous active-high reset
//   i_update            one-cycle pulse, latch the request fields below
//   i_req_rd_segment    requested segment
//   i_transition_mode   mode code (00 SYNC_IDX, 01 SYS_TIME, 02 GPIO,
//                       F0 EXT, FF IMMEDIATE)
//   i_transition_value  mode argument (time, or GPIO index in bits [1:0])
//   i_rep0 / i_rep1     repeat count per segment, 16'hFFFF = infinite
//   i_idx_wrap          read index wrapped from the last entry to 0
//   i_sys_time          synchronized free-running system time
//   i_gpio_in           synchronized external trigger lines
//   o_segment           active read segment
//   o_stop              repeat count exhausted, read path holds
//   o_switched          one-cycle pulse when o_segment is (re)loaded
//   o_pending           a request is latched and waiting
//   o_err               one-cycle pulse after an UPDATE with an invalid mode
// -----------------------------------------------------------------------------
module seg_transition_ctl #(
  parameter int SYS_TIME_W = 64,
  parameter int GPIO_W     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_update,
  input  logic                  i_req_rd_segment,
  input  logic [7:0]            i_transition_mode,
  input  logic [SYS_TIME_W-1:0] i_transition_value,
  input  logic [15:0]           i_rep0,
  input  logic [15:0]           i_rep1,
  input  logic                  i_idx_wrap,
  input  logic [SYS_TIME_W-1:0] i_sys_time,
  input  logic [GPIO_W-1:0]     i_gpio_in,
  output logic                  o_segment,
  output logic                  o_stop,
  output logic                  o_switched,
  output logic                  o_pending,
  output logic                  o_err
);

  localparam logic [7:0]  MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0]  MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0]  MODE_GPIO      = 8'h02;
  localparam logic [7:0]  MODE_EXT       = 8'hF0;
  localparam logic [7:0]  MODE_IMMEDIATE = 8'hFF;
  localparam logic [15:0] REP_INFINITE   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Accepted mode codes; GPIO only when the trigger hardware is built in.
  function automatic logic f_mode_valid(input logic [7:0] mode);
    logic v;
    case (mode)
      MODE_SYNC_IDX, MODE_SYS_TIME, MODE_EXT, MODE_IMMEDIATE: v = 1'b1;
`ifdef TRANSITION_GPIO_EN
      MODE_GPIO: v = 1'b1;
`endif
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  state_t                r_state;
  logic                  r_segment;
  logic                  r_stop;
  logic                  r_switched;
  logic                  r_pending;
  logic                  r_err;
  logic                  r_tgt_seg;
  logic [7:0]            r_mode;
  logic [SYS_TIME_W-1:0] r_value;
  logic [15:0]           r_loop_cnt;
  logic                  r_ext_armed;

  logic                  w_gpio_rise;
  logic                  w_cond;
  logic                  w_trigger;
  logic [15:0]           w_rep_cur;
  logic                  w_counting;
  logic                  w_exhaust;
  logic                  w_update_ok;

`ifdef TRANSITION_GPIO_EN
  logic [GPIO_W-1:0]     r_gpio_d;

  // Rising edge of the selected GPIO line against its one-cycle delayed copy.
  always_comb begin
    w_gpio_rise = i_gpio_in[r_value[1:0]] & ~r_gpio_d[r_value[1:0]];
  end

  // Delayed copy of the GPIO lines used for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gpio_d <= {GPIO_W{1'b0}};
    end else begin
      r_gpio_d <= i_gpio_in;
    end
  end
`else
  logic                  w_unused_gpio;
  assign w_unused_gpio = ^i_gpio_in;
  assign w_gpio_rise   = 1'b0;
`endif

  // Trigger and repeat-exhaustion conditions for the current cycle.
  always_comb begin
    w_cond = 1'b0;
    case (r_mode)
      // While stopped, no further wraps arrive, so the sync point is now.
      MODE_SYNC_IDX:  w_cond = i_idx_wrap | r_stop;
      MODE_SYS_TIME:  w_cond = (i_sys_time >= r_value);
      MODE_GPIO:      w_cond = w_gpio_rise;
      MODE_EXT:       w_cond = 1'b1;
      MODE_IMMEDIATE: w_cond = 1'b1;
      default:        w_cond = 1'b0;
    endcase
    w_trigger   = (r_state == ST_WAIT) && w_cond;
    w_rep_cur   = r_segment ? i_rep1 : i_rep0;
    w_counting  = (r_state != ST_HALT) && i_idx_wrap && (w_rep_cur != REP_INFINITE);
    // The counter equals REP on the wrap that ends play number REP+1.
    w_exhaust   = w_counting && (r_loop_cnt == w_rep_cur);
    w_update_ok = i_update && f_mode_valid(i_transition_mode);
  end

  // Sequencer: request latch, segment switching, repeat counting, halt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_RUN;
      r_segment   <= 1'b0;
      r_stop      <= 1'b0;
      r_switched  <= 1'b0;
      r_pending   <= 1'b0;
      r_err       <= 1'b0;
      r_tgt_seg   <= 1'b0;
      r_mode      <= MODE_SYNC_IDX;
      r_value     <= {SYS_TIME_W{1'b0}};
      r_loop_cnt  <= 16'd0;
      r_ext_armed <= 1'b0;
    end else begin
      r_switched <= 1'b0;
      r_err      <= i_update && !f_mode_valid(i_transition_mode);

      // A firing trigger takes priority over exhaustion in the same cycle.
      if (w_trigger) begin
        r_segment   <= r_tgt_seg;
        r_switched  <= 1'b1;
        r_pending   <= 1'b0;
        r_loop_cnt  <= 16'd0;
        r_stop      <= 1'b0;
        r_state     <= ST_RUN;
        r_ext_armed <= (r_mode == MODE_EXT);
      end else if (w_exhaust) begin
        if (r_ext_armed) begin
          r_segment  <= ~r_segment;
          r_switched <= 1'b1;
          r_loop_cnt <= 16'd0;
        end else begin
          r_state   <= ST_HALT;
          r_stop    <= 1'b1;
          r_pending <= 1'b0;
        end
      end else if (w_counting && (r_loop_cnt != 16'hFFFF)) begin
        r_loop_cnt <= r_loop_cnt + 16'd1;
      end else begin
        r_loop_cnt <= r_loop_cnt;
      end

      // A valid UPDATE is latched after any old request has fired.
      if (w_update_ok) begin
        r_tgt_seg <= i_req_rd_segment;
        r_mode    <= i_transition_mode;
        r_value   <= i_transition_value;
        r_state   <= ST_WAIT;
        r_pending <= 1'b1;
        if (i_transition_mode != MODE_EXT) begin
          r_ext_armed <= 1'b0;
        end
      end
    end
  end

  assign o_segment  = r_segment;
  assign o_stop     = r_stop;
  assign o_switched = r_switched;
  assign o_pending  = r_pending;
  assign o_err      = r_err;

endmodule
